// File: rtl/ctrl_word_monitor.sv
// Passive monitor for the 25-bit sequencer control-word bus: decodes words to micro-op codes,
// flags illegal words and idle->restart violations, buffers codes in a history FIFO, counts errors.
module ctrl_word_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [24:0]      y_in,
    input  logic             clr_err,
    input  logic             rd_en,
    output logic [3:0]       code_o,
    output logic             code_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [4:0]       rd_data,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic {
        IDLE_OK,
        WAIT_RESTART
    } chk_state_t;

    // ------------------------------------------------------------------
    // Word decode: exact match against the legal control-word table
    // ------------------------------------------------------------------
    logic [3:0] dec_code;
    logic       dec_legal;

    always_comb begin
        dec_code  = '0;
        dec_legal = 1'b1;
        case (y_in)
            25'h0000000: dec_code = 4'd0;
            25'h0000400: dec_code = 4'd1;
            25'h000007A: dec_code = 4'd2;
            25'h0402078: dec_code = 4'd3;
            25'h0010100: dec_code = 4'd4;
            25'h000C088: dec_code = 4'd5;
            25'h004000E: dec_code = 4'd6;
            25'h08000C8: dec_code = 4'd7;
            25'h000403A: dec_code = 4'd8;
            25'h0000300: dec_code = 4'd9;
            25'h010200C: dec_code = 4'd10;
            25'h000084A: dec_code = 4'd11;
            25'h02A8008: dec_code = 4'd12;
            25'h0003038: dec_code = 4'd13;
            25'h1020003: dec_code = 4'd14;
            25'h00A000A: dec_code = 4'd15;
            default: begin
                dec_code  = '0;
                dec_legal = 1'b0;
            end
        endcase
    end

    logic is_idle_word;
    logic is_restart_word;
    logic ill_hit;

    assign is_idle_word    = dec_legal && (dec_code == 4'd0);
    assign is_restart_word = dec_legal && (dec_code == 4'd1);
    assign ill_hit         = sample_en && !dec_legal;

    // ------------------------------------------------------------------
    // Sequence checker: idle word must be followed by the restart word
    // ------------------------------------------------------------------
    chk_state_t state;
    chk_state_t state_nxt;
    logic       seq_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_OK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seq_hit   = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE_OK: begin
                    if (is_idle_word) begin
                        state_nxt = WAIT_RESTART;
                    end
                end
                WAIT_RESTART: begin
                    if (is_restart_word) begin
                        state_nxt = IDLE_OK;
                    end else begin
                        // A repeated idle word re-arms the wait; anything else drops it.
                        seq_hit   = 1'b1;
                        state_nxt = is_idle_word ? WAIT_RESTART : IDLE_OK;
                    end
                end
                default: state_nxt = IDLE_OK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered decode outputs and pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_o   <= '0;
            code_vld <= 1'b0;
            illegal  <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            code_vld <= sample_en;
            illegal  <= ill_hit;
            seq_err  <= seq_hit;
            if (sample_en) begin
                code_o <= dec_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter; clear beats same-cycle events
    // ------------------------------------------------------------------
    logic [CNT_W+1:0] cnt_sum;

    always_comb begin
        cnt_sum = {2'b00, err_cnt}
                + {{(CNT_W + 1){1'b0}}, ill_hit}
                + {{(CNT_W + 1){1'b0}}, seq_hit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (cnt_sum > CNT_MAX) begin
            err_cnt <= '1;
        end else begin
            err_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // History FIFO of {illegal_bit, code}
    // ------------------------------------------------------------------
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign full    = (count == DEPTH_C);
    assign do_pop  = rd_en && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = sample_en && (!full || do_pop);
    assign drop    = sample_en && full && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {ill_hit, dec_code};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = full;

endmodule

// File: tb/tb_ctrl_word_monitor.sv
// Self-checking bench for ctrl_word_monitor: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ctrl_word_monitor;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_en = 1'b0;
    logic [24:0]      y_in = '0;
    logic             clr_err = 1'b0;
    logic             rd_en = 1'b0;
    logic [3:0]       code_o;
    logic             code_vld;
    logic             illegal;
    logic             seq_err;
    logic [CNT_W-1:0] err_cnt;
    logic [4:0]       rd_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;

    ctrl_word_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .y_in(y_in),
        .clr_err(clr_err), .rd_en(rd_en), .code_o(code_o), .code_vld(code_vld),
        .illegal(illegal), .seq_err(seq_err), .err_cnt(err_cnt), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Legal word table as lists of asserted y indices (0 = unused slot)
    int bits_tab [16][6] = '{
        '{0, 0, 0, 0, 0, 0},   '{11, 0, 0, 0, 0, 0},   '{2, 4, 5, 6, 7, 0},
        '{4, 5, 6, 7, 14, 23}, '{9, 17, 0, 0, 0, 0},   '{4, 8, 15, 16, 0, 0},
        '{2, 3, 4, 19, 0, 0},  '{4, 7, 8, 24, 0, 0},   '{2, 4, 5, 6, 15, 0},
        '{9, 10, 0, 0, 0, 0},  '{3, 4, 14, 21, 0, 0},  '{2, 4, 7, 12, 0, 0},
        '{4, 16, 18, 20, 22, 0}, '{4, 5, 6, 13, 14, 0}, '{1, 2, 18, 25, 0, 0},
        '{2, 4, 18, 20, 0, 0}
    };
    logic [24:0] mask [16];

    // ---------------- behavioural model ----------------
    logic [3:0]  m_code = '0;
    bit          m_vld = 0, m_ill = 0, m_seq = 0, m_ovf = 0, m_pending = 0;
    int          m_cnt = 0;
    logic [4:0]  m_rd = '0;
    logic [4:0]  m_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_code = '0; m_vld = 0; m_ill = 0; m_seq = 0; m_ovf = 0;
            m_pending = 0; m_cnt = 0; m_rd = '0; m_q.delete();
        end else begin
            int  k;
            int  sz;
            bit  popped;
            k = -1;
            m_vld = sample_en; m_ill = 0; m_seq = 0;
            sz = m_q.size();
            popped = rd_en && (sz > 0);
            if (popped) m_rd = m_q.pop_front();
            if (sample_en) begin
                for (int i = 0; i < 16; i++) if (y_in == mask[i]) k = i;
                m_ill  = (k < 0);
                m_code = m_ill ? 4'd0 : 4'(k);
                m_seq  = m_pending && (k != 1);
                m_pending = (k == 0);
                if (sz < DEPTH || popped) m_q.push_back({m_ill, m_code});
                else m_ovf = 1;
            end
            if (clr_err) begin
                m_cnt = 0; m_ovf = 0;
            end else begin
                m_cnt = m_cnt + int'(m_ill) + int'(m_seq);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            end
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            chk("code_o", 32'(code_o), 32'(m_code));
            chk("code_vld", 32'(code_vld), 32'(m_vld));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("seq_err", 32'(seq_err), 32'(m_seq));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("rd_data", 32'(rd_data), 32'(m_rd));
            chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
            chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic step(input bit se, input logic [24:0] y, input bit clr, input bit rd);
        sample_en = se; y_in = y; clr_err = clr; rd_en = rd;
        @(posedge clk);
        #1;
        sample_en = 0; clr_err = 0; rd_en = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mask[i] = '0;
            for (int j = 0; j < 6; j++)
                if (bits_tab[i][j] != 0) mask[i] = mask[i] | (25'd1 << (bits_tab[i][j] - 1));
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        armed = 1'b1;

        // reset state and first decode
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        step(1, 25'h0000400, 0, 0);
        chk("y11_code", 32'(code_o), 32'd1);
        chk("y11_vld", 32'(code_vld), 32'd1);
        chk("y11_ill", 32'(illegal), 32'd0);
        step(0, '0, 0, 0);
        chk("vld_pulse", 32'(code_vld), 32'd0);
        step(0, '0, 0, 1);
        chk("y11_fifo", 32'(rd_data), 32'h01);
        chk("y11_empty", 32'(fifo_empty), 32'd1);

        // sequencing rule
        step(1, 25'h0, 0, 0);
        step(1, 25'h0000400, 0, 0);
        chk("restart_ok", 32'(seq_err), 32'd0);
        step(1, 25'h0, 0, 0);
        step(1, 25'h004000E, 0, 0);
        chk("seq_pulse", 32'(seq_err), 32'd1);
        chk("seq_code", 32'(code_o), 32'd6);
        chk("seq_cnt", 32'(err_cnt), 32'd1);

        // illegal word
        do_reset();
        step(1, 25'h1FFFFFF, 0, 0);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_code", 32'(code_o), 32'd0);
        chk("ill_cnt", 32'(err_cnt), 32'd1);
        step(0, '0, 0, 1);
        chk("ill_fifo", 32'(rd_data), 32'h10);
        step(1, 25'h0000400, 0, 0);
        chk("ill_noseq", 32'(seq_err), 32'd0);
        chk("ill_cnt2", 32'(err_cnt), 32'd1);

        // FIFO full / overflow / simultaneous push+pop / drain
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, mask[i], 0, 0);
            if (i == 7) begin
                chk("full8", 32'(fifo_full), 32'd1);
                chk("noovf8", 32'(overflow), 32'd0);
            end
        end
        chk("ovf9", 32'(overflow), 32'd1);
        step(1, mask[9], 0, 1);
        chk("pp_data", 32'(rd_data), 32'h00);
        chk("pp_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 0, 1);
            chk("drain", 32'(rd_data), (i < 7) ? 32'(i + 1) : 32'd9);
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        step(0, '0, 0, 1);
        chk("empty_rd_hold", 32'(rd_data), 32'd9);

        // counter saturation and clear priority
        do_reset();
        for (int i = 0; i < 260; i++) step(1, 25'h1FFFFFF, 0, 0);
        chk("sat", 32'(err_cnt), 32'd255);
        step(1, 25'h1FFFFFF, 1, 0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // reset while waiting for restart
        do_reset();
        step(1, 25'h0000400, 0, 0);
        step(1, 25'h0, 0, 0);
        rst = 1'b1;
        #2;
        chk("mid_code", 32'(code_o), 32'd0);
        chk("mid_vld", 32'(code_vld), 32'd0);
        chk("mid_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rd", 32'(rd_data), 32'd0);
        chk("mid_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 25'h000C088, 0, 0);
        chk("post_code", 32'(code_o), 32'd5);
        chk("post_noseq", 32'(seq_err), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [24:0] y;
            case ($urandom_range(0, 4))
                0, 1:    y = mask[$urandom_range(0, 1)];
                2:       y = mask[$urandom_range(0, 15)];
                3:       y = mask[$urandom_range(0, 15)] ^ (25'd1 << $urandom_range(0, 24));
                default: y = 25'($urandom());
            endcase
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, y, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 4);
        end

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
